// File: rtl/draw_scoreboard.sv
// rtl/draw_scoreboard.sv - two-digit seven-segment score overlay, 2-clock pipeline
// Optional blink-on-change feature: define SCOREBOARD_FLASH_EN.
module draw_scoreboard #(
    parameter int          P1_X      = 440,
    parameter int          P2_X      = 536,
    parameter int          SCORE_Y   = 16,
    parameter int          DIGIT_W   = 24,
    parameter int          DIGIT_H   = 40,
    parameter int          SEG_T     = 4,
    parameter int          DIGIT_GAP = 8,
    parameter logic [11:0] COLOR     = 12'hfff
) (
    input  logic        clk_in,
    input  logic        rst,
    input  logic [11:0] hcount_in,
    input  logic [11:0] vcount_in,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        hblnk_in,
    input  logic        vblnk_in,
    input  logic [11:0] rgb_in,
    input  logic [4:0]  player_1_score,
    input  logic [4:0]  player_2_score,
    output logic [11:0] hcount_out,
    output logic [11:0] vcount_out,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        hblnk_out,
    output logic        vblnk_out,
    output logic [11:0] rgb_out
);

    localparam logic [11:0] X_P1T = 12'(P1_X);
    localparam logic [11:0] X_P1U = 12'(P1_X + DIGIT_W + DIGIT_GAP);
    localparam logic [11:0] X_P2T = 12'(P2_X);
    localparam logic [11:0] X_P2U = 12'(P2_X + DIGIT_W + DIGIT_GAP);
    localparam logic [11:0] W12   = 12'(DIGIT_W);
    localparam logic [11:0] Y_TOP = 12'(SCORE_Y);
    localparam logic [11:0] Y_END = 12'(SCORE_Y + DIGIT_H);
    localparam logic [5:0]  T6    = 6'(SEG_T);
    localparam logic [5:0]  WT6   = 6'(DIGIT_W - SEG_T);
    localparam logic [5:0]  HT6   = 6'(DIGIT_H - SEG_T);
    localparam logic [5:0]  M6    = 6'((DIGIT_H - SEG_T) / 2);
    localparam logic [5:0]  MT6   = 6'((DIGIT_H - SEG_T) / 2 + SEG_T);
    localparam logic [5:0]  H26   = 6'(DIGIT_H / 2);

    typedef enum logic [1:0] {IDLE, CONV_P1, CONV_P2, COMMIT} state_t;

    state_t      state_q, state_d;
    logic        vblnk_d_q, vblnk_d_d;
    logic [4:0]  s1_q, s1_d, s2_q, s2_d;
    logic [4:0]  rem_q, rem_d;
    logic [1:0]  tens_q, tens_d;
    logic        load_q, load_d;
    logic [1:0]  p1t_q, p1t_d;
    logic [3:0]  p1u_q, p1u_d;
    logic [1:0]  d1t_q, d1t_d, d2t_q, d2t_d;
    logic [3:0]  d1u_q, d1u_d, d2u_q, d2u_d;
    logic        capture;
    logic [4:0]  op;
    logic        show1, show2;

    // stage 1
    logic [11:0] h1_q, h1_d, v1_q, v1_d, rgb1_q, rgb1_d;
    logic        hs1_q, hs1_d, vs1_q, vs1_d, hb1_q, hb1_d, vb1_q, vb1_d;
    logic [2:0]  box_q, box_d;
    logic [5:0]  lx_q, lx_d, ly_q, ly_d;
    // stage 2
    logic [11:0] h2_q, h2_d, v2_q, v2_d, rgb2_q, rgb2_d;
    logic        hs2_q, hs2_d, vs2_q, vs2_d, hb2_q, hb2_d, vb2_q, vb2_d;

`ifdef SCOREBOARD_FLASH_EN
    logic [5:0]  fl1_q, fl1_d, fl2_q, fl2_d;
    assign show1 = (fl1_q == 6'd0) || fl1_q[3];
    assign show2 = (fl2_q == 6'd0) || fl2_q[3];
`else
    assign show1 = 1'b1;
    assign show2 = 1'b1;
`endif

    assign capture = vblnk_in & ~vblnk_d_q;
    assign op      = load_q ? s1_q : rem_q;

    always_comb begin
        state_d   = state_q;
        vblnk_d_d = vblnk_in;
        s1_d      = s1_q;
        s2_d      = s2_q;
        rem_d     = rem_q;
        tens_d    = tens_q;
        load_d    = load_q;
        p1t_d     = p1t_q;
        p1u_d     = p1u_q;
        d1t_d     = d1t_q;
        d1u_d     = d1u_q;
        d2t_d     = d2t_q;
        d2u_d     = d2u_q;
`ifdef SCOREBOARD_FLASH_EN
        fl1_d     = fl1_q;
        fl2_d     = fl2_q;
        if (capture) begin
            if (fl1_q != 6'd0) fl1_d = fl1_q - 6'd1;
            if (fl2_q != 6'd0) fl2_d = fl2_q - 6'd1;
        end
`endif
        if (capture) begin
            s1_d = player_1_score;
            s2_d = player_2_score;
        end
        case (state_q)
            IDLE: begin
                if (capture) begin
                    load_d  = 1'b1;
                    tens_d  = 2'd0;
                    state_d = CONV_P1;
                end
            end
            CONV_P1: begin
                load_d = 1'b0;
                if (op >= 5'd10) begin
                    rem_d  = op - 5'd10;
                    tens_d = tens_q + 2'd1;
                end else begin
                    p1t_d   = tens_q;
                    p1u_d   = op[3:0];
                    rem_d   = s2_q;
                    tens_d  = 2'd0;
                    state_d = CONV_P2;
                end
            end
            CONV_P2: begin
                if (rem_q >= 5'd10) begin
                    rem_d  = rem_q - 5'd10;
                    tens_d = tens_q + 2'd1;
                end else begin
                    state_d = COMMIT;
                end
            end
            COMMIT: begin
                d1t_d   = p1t_q;
                d1u_d   = p1u_q;
                d2t_d   = tens_q;
                d2u_d   = rem_q[3:0];
`ifdef SCOREBOARD_FLASH_EN
                if ({p1t_q, p1u_q} != {d1t_q, d1u_q}) fl1_d = 6'd63;
                if ({tens_q, rem_q[3:0]} != {d2t_q, d2u_q}) fl2_d = 6'd63;
`endif
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Stage 1: locate the pixel in one of the four digit boxes.
    always_comb begin
        h1_d   = hcount_in;
        v1_d   = vcount_in;
        hs1_d  = hsync_in;
        vs1_d  = vsync_in;
        hb1_d  = hblnk_in;
        vb1_d  = vblnk_in;
        rgb1_d = rgb_in;
        box_d  = 3'd0;
        lx_d   = 6'd0;
        ly_d   = 6'(vcount_in - Y_TOP);
        if (vcount_in >= Y_TOP && vcount_in < Y_END) begin
            if (hcount_in >= X_P1T && hcount_in < X_P1T + W12) begin
                box_d = 3'd4;
                lx_d  = 6'(hcount_in - X_P1T);
            end else if (hcount_in >= X_P1U && hcount_in < X_P1U + W12) begin
                box_d = 3'd5;
                lx_d  = 6'(hcount_in - X_P1U);
            end else if (hcount_in >= X_P2T && hcount_in < X_P2T + W12) begin
                box_d = 3'd6;
                lx_d  = 6'(hcount_in - X_P2T);
            end else if (hcount_in >= X_P2U && hcount_in < X_P2U + W12) begin
                box_d = 3'd7;
                lx_d  = 6'(hcount_in - X_P2U);
            end
        end
    end

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)                 // {a,b,c,d,e,f,g}
            4'd0:    seg7 = 7'b1111110;
            4'd1:    seg7 = 7'b0110000;
            4'd2:    seg7 = 7'b1101101;
            4'd3:    seg7 = 7'b1111001;
            4'd4:    seg7 = 7'b0110011;
            4'd5:    seg7 = 7'b1011011;
            4'd6:    seg7 = 7'b1011111;
            4'd7:    seg7 = 7'b1110000;
            4'd8:    seg7 = 7'b1111111;
            4'd9:    seg7 = 7'b1111011;
            default: seg7 = 7'b0000000;
        endcase
    endfunction

    logic [3:0] dig;
    logic       draw, lit;
    logic [6:0] segs;
    logic [6:0] area;

    // Stage 2: segment decode and pixel mux; a zero tens digit stays blank.
    always_comb begin
        dig  = 4'd0;
        draw = 1'b0;
        case (box_q)
            3'd4: begin dig = {2'b00, d1t_q}; draw = show1 && (d1t_q != 2'd0); end
            3'd5: begin dig = d1u_q;          draw = show1;                    end
            3'd6: begin dig = {2'b00, d2t_q}; draw = show2 && (d2t_q != 2'd0); end
            3'd7: begin dig = d2u_q;          draw = show2;                    end
            default: ;
        endcase
        segs = seg7(dig);
        area[6] = ly_q < T6;
        area[5] = lx_q >= WT6 && ly_q <  H26;
        area[4] = lx_q >= WT6 && ly_q >= H26;
        area[3] = ly_q >= HT6;
        area[2] = lx_q < T6 && ly_q >= H26;
        area[1] = lx_q < T6 && ly_q <  H26;
        area[0] = ly_q >= M6 && ly_q < MT6;
        lit  = draw && ((segs & area) != 7'd0);
        h2_d  = h1_q;
        v2_d  = v1_q;
        hs2_d = hs1_q;
        vs2_d = vs1_q;
        hb2_d = hb1_q;
        vb2_d = vb1_q;
        if (hb1_q || vb1_q) rgb2_d = 12'h000;
        else if (lit)       rgb2_d = COLOR;
        else                rgb2_d = rgb1_q;
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            vblnk_d_q <= 1'b0;
            s1_q      <= 5'd0;
            s2_q      <= 5'd0;
            rem_q     <= 5'd0;
            tens_q    <= 2'd0;
            load_q    <= 1'b0;
            p1t_q     <= 2'd0;
            p1u_q     <= 4'd0;
            d1t_q     <= 2'd0;
            d1u_q     <= 4'd0;
            d2t_q     <= 2'd0;
            d2u_q     <= 4'd0;
`ifdef SCOREBOARD_FLASH_EN
            fl1_q     <= 6'd0;
            fl2_q     <= 6'd0;
`endif
        end else begin
            state_q   <= state_d;
            vblnk_d_q <= vblnk_d_d;
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            rem_q     <= rem_d;
            tens_q    <= tens_d;
            load_q    <= load_d;
            p1t_q     <= p1t_d;
            p1u_q     <= p1u_d;
            d1t_q     <= d1t_d;
            d1u_q     <= d1u_d;
            d2t_q     <= d2t_d;
            d2u_q     <= d2u_d;
`ifdef SCOREBOARD_FLASH_EN
            fl1_q     <= fl1_d;
            fl2_q     <= fl2_d;
`endif
        end
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            h1_q <= '0; v1_q <= '0; rgb1_q <= '0;
            hs1_q <= 1'b0; vs1_q <= 1'b0; hb1_q <= 1'b0; vb1_q <= 1'b0;
            box_q <= '0; lx_q <= '0; ly_q <= '0;
            h2_q <= '0; v2_q <= '0; rgb2_q <= '0;
            hs2_q <= 1'b0; vs2_q <= 1'b0; hb2_q <= 1'b0; vb2_q <= 1'b0;
        end else begin
            h1_q <= h1_d; v1_q <= v1_d; rgb1_q <= rgb1_d;
            hs1_q <= hs1_d; vs1_q <= vs1_d; hb1_q <= hb1_d; vb1_q <= vb1_d;
            box_q <= box_d; lx_q <= lx_d; ly_q <= ly_d;
            h2_q <= h2_d; v2_q <= v2_d; rgb2_q <= rgb2_d;
            hs2_q <= hs2_d; vs2_q <= vs2_d; hb2_q <= hb2_d; vb2_q <= vb2_d;
        end
    end

    assign hcount_out = h2_q;
    assign vcount_out = v2_q;
    assign hsync_out  = hs2_q;
    assign vsync_out  = vs2_q;
    assign hblnk_out  = hb2_q;
    assign vblnk_out  = vb2_q;
    assign rgb_out    = rgb2_q;

endmodule
